// File: rtl/gate_sweep_checker.sv
`timescale 1us/1ns
// Sweeps all 16 {a,b,c,d} vectors into the gate bank and, after a settle delay,
// checks the ten gate outputs against their golden Boolean functions.
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5,
    parameter bit LOOP          = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [3:0]       abcd,
    input  logic [9:0]       gate_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_fail_valid,
    output logic [3:0]       first_fail_vec,
    output logic [9:0]       first_fail_mask
);
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

    state_e             state_q, state_d;
    logic [3:0]         vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         abcd_q, abcd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               first_fail_valid_q, first_fail_valid_d;
    logic [3:0]         first_fail_vec_q, first_fail_vec_d;
    logic [9:0]         first_fail_mask_q, first_fail_mask_d;
    logic [9:0]         mask;

    // Bit order follows gate_out: [0]=o1 ... [9]=o10.
    function automatic logic [9:0] golden(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        golden = {a & b, c, ~d, c, ~(b ^ d), a ^ b ^ c, ~(c | d), a | b | c | d, ~(c & d), a & b};
    endfunction

    always_comb begin
        state_d            = state_q;
        vec_d              = vec_q;
        cnt_d              = cnt_q;
        pass_d             = pass_q;
        err_cnt_d          = err_cnt_q;
        first_fail_valid_d = first_fail_valid_q;
        first_fail_vec_d   = first_fail_vec_q;
        first_fail_mask_d  = first_fail_mask_q;
        mask               = gate_out ^ golden(vec_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_cnt_d          = '0;
                    first_fail_valid_d = 1'b0;
                    first_fail_vec_d   = '0;
                    first_fail_mask_d  = '0;
                    pass_d             = 1'b0;
                    vec_d              = '0;
                    cnt_d              = CNT_RELOAD;
                    state_d            = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = CHECK;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            CHECK: begin
                if (mask != '0) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                    if (!first_fail_valid_q) begin
                        first_fail_valid_d = 1'b1;
                        first_fail_vec_d   = vec_q;
                        first_fail_mask_d  = mask;
                    end
                end
                if (vec_q == 4'hF) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = CNT_RELOAD;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                if (LOOP) begin
                    err_cnt_d          = '0;
                    first_fail_valid_d = 1'b0;
                    first_fail_vec_d   = '0;
                    first_fail_mask_d  = '0;
                    pass_d             = 1'b0;
                    vec_d              = '0;
                    cnt_d              = CNT_RELOAD;
                    state_d            = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        if (state_d == DONE) pass_d = (err_cnt_d == '0);
        busy_d = (state_d == SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        abcd_d = busy_d ? vec_d : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            vec_q              <= '0;
            cnt_q              <= '0;
            abcd_q             <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            err_cnt_q          <= '0;
            first_fail_valid_q <= 1'b0;
            first_fail_vec_q   <= '0;
            first_fail_mask_q  <= '0;
        end else begin
            state_q            <= state_d;
            vec_q              <= vec_d;
            cnt_q              <= cnt_d;
            abcd_q             <= abcd_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            pass_q             <= pass_d;
            err_cnt_q          <= err_cnt_d;
            first_fail_valid_q <= first_fail_valid_d;
            first_fail_vec_q   <= first_fail_vec_d;
            first_fail_mask_q  <= first_fail_mask_d;
        end
    end

    assign abcd             = abcd_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_cnt          = err_cnt_q;
    assign first_fail_valid = first_fail_valid_q;
    assign first_fail_vec   = first_fail_vec_q;
    assign first_fail_mask  = first_fail_mask_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
`timescale 1us/1ns
// Bench for gate_sweep_checker: a faultable gate bank model feeds two checker
// instances (single-shot and looping) whose results are compared to a sweep model.
module tb_gate_sweep_checker;

    localparam int S_A = 2;   // instance A: single sweep, 5-bit counter
    localparam int S_B = 0;   // instance B: looping, 3-bit counter, settle 0 acts as 1

    logic       clk;
    logic       rst_n;
    int         n_checks = 0;
    int         n_errors = 0;

    logic       start_a, start_b;
    logic [3:0] abcd_a, abcd_b;
    logic [9:0] gate_a, gate_b;
    logic [9:0] stuck0_a, stuck1_a, stuck0_b;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [4:0] err_a;
    logic [2:0] err_b;
    logic [3:0] ffvec_a, ffvec_b;
    logic [9:0] ffmask_a, ffmask_b;

    // clock / reset block
    initial clk = 1'b0;
    always #0.5 clk = ~clk;

    function automatic logic [9:0] golden(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        golden = {a & b, c, ~d, c, ~(b ^ d), a ^ b ^ c, ~(c | d), a | b | c | d, ~(c & d), a & b};
    endfunction

    // Gate bank with stuck-at-0 / stuck-at-1 fault injection per output.
    assign gate_a = (golden(abcd_a) & ~stuck0_a) | stuck1_a;
    assign gate_b = golden(abcd_b) & ~stuck0_b;

    gate_sweep_checker #(.SETTLE_CYCLES(S_A), .ERR_W(5), .LOOP(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abcd(abcd_a), .gate_out(gate_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a), .first_fail_mask(ffmask_a)
    );

    gate_sweep_checker #(.SETTLE_CYCLES(S_B), .ERR_W(3), .LOOP(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abcd(abcd_b), .gate_out(gate_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b), .first_fail_mask(ffmask_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Whole-sweep outcome for a given fault pattern, straight from the golden table.
    task automatic ref_sweep(input logic [9:0] s0, input logic [9:0] s1, input int errw,
                             output int n, output bit ffv, output logic [3:0] fvec,
                             output logic [9:0] fmask);
        logic [9:0] want, seen;
        n = 0; ffv = 1'b0; fvec = '0; fmask = '0;
        for (int v = 0; v < 16; v++) begin
            want = golden(4'(v));
            seen = (want & ~s0) | s1;
            if (seen != want) begin
                if (n < (1 << errw) - 1) n++;
                if (!ffv) begin
                    ffv = 1'b1; fvec = 4'(v); fmask = seen ^ want;
                end
            end
        end
    endtask

    // driver + scoreboard for one single-shot sweep on instance A
    task automatic sweep_a(input logic [9:0] s0, input logic [9:0] s1, input bit poke);
        int         cyc, n, bad, extra_done;
        bit         fv;
        logic [3:0] fvec, e;
        logic [9:0] fmask;
        logic [3:0] exp_q[$];
        stuck0_a = s0; stuck1_a = s1;
        ref_sweep(s0, s1, 5, n, fv, fvec, fmask);
        for (int v = 0; v < 16; v++)
            for (int r = 0; r <= S_A; r++) exp_q.push_back(4'(v));
        start_a = 1'b1;
        @(posedge clk); #0.1;
        start_a = 1'b0; cyc = 1; bad = 0;
        while (!done_a && cyc < 200) begin
            if (busy_a && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (abcd_a !== e) bad++;
            end else begin
                bad++;
            end
            start_a = poke && (abcd_a == 4'd3 || abcd_a == 4'd9);
            @(posedge clk); #0.1; cyc++;
        end
        start_a = 1'b0;
        check("done_seen", done_a, 1);
        check("latency", cyc, 16 * (S_A + 1) + 1);
        check("abcd_seq_bad", bad, 0);
        check("abcd_seq_left", exp_q.size(), 0);
        check("busy_at_done", busy_a, 0);
        check("pass", pass_a, (n == 0));
        check("err_cnt", err_a, n);
        check("ff_valid", ffv_a, fv);
        check("ff_vec", ffvec_a, fvec);
        check("ff_mask", ffmask_a, fmask);
        @(posedge clk); #0.1;
        check("done_pulse_len", done_a, 0);
        check("idle_abcd", abcd_a, 0);
        extra_done = 0;
        repeat (4) begin
            @(posedge clk); #0.1;
            if (done_a || busy_a) extra_done++;
        end
        check("idle_quiet", extra_done, 0);
        check("pass_held", pass_a, (n == 0));
        check("err_held", err_a, n);
    endtask

    task automatic reset_abort();
        int k, dn;
        stuck0_a = 10'h3FF; stuck1_a = '0;
        start_a = 1'b1;
        @(posedge clk); #0.1;
        start_a = 1'b0; k = 0;
        while (abcd_a != 4'd7 && k < 100) begin
            @(posedge clk); #0.1; k++;
        end
        check("reach_vec7", abcd_a, 7);
        check("err_before_rst", err_a, 7);
        #0.2;
        rst_n = 1'b0;
        #0.001;
        check("rst_outputs_a", {abcd_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a, ffmask_a}, 0);
        rst_n = 1'b1;
        dn = 0;
        repeat (60) begin
            @(posedge clk); #0.1;
            if (done_a || busy_a) dn++;
        end
        check("no_done_after_abort", dn, 0);
        sweep_a('0, '0, 1'b0);
    endtask

    task automatic loop_b();
        int         cyc, last, ndone, busy_bad, wrap_bad, n, prev;
        bit         fv;
        logic [3:0] fvec;
        logic [9:0] fmask, cur_s0;
        cur_s0 = 10'h3FF; stuck0_b = cur_s0;
        start_b = 1'b1;
        @(posedge clk); #0.1;
        start_b = 1'b0;
        cyc = 1; last = 0; ndone = 0; busy_bad = 0; wrap_bad = 0; prev = 0;
        while (ndone < 3 && cyc < 400) begin
            if (ndone == 0) begin
                if (int'(err_b) < prev) wrap_bad++;
                prev = int'(err_b);
            end
            if (done_b) begin
                ref_sweep(cur_s0, '0, 3, n, fv, fvec, fmask);
                check("loop_interval", cyc - last, 16 * 2 + 1);
                check("loop_busy_done", busy_b, 0);
                check("loop_err", err_b, n);
                check("loop_pass", pass_b, (n == 0));
                check("loop_ffv", ffv_b, fv);
                check("loop_ffvec", ffvec_b, fvec);
                check("loop_ffmask", ffmask_b, fmask);
                last = cyc; ndone++;
                cur_s0 = '0; stuck0_b = cur_s0;
            end else if (!busy_b) begin
                busy_bad++;
            end
            @(posedge clk); #0.1; cyc++;
        end
        check("loop_done_count", ndone, 3);
        check("loop_busy_gaps", busy_bad, 0);
        check("sat_no_wrap", wrap_bad, 0);
    endtask

    initial begin
        logic [9:0] r0, r1;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        stuck0_a = '0; stuck1_a = '0; stuck0_b = '0;
        repeat (3) @(posedge clk);
        #0.1;
        check("rst_a", {abcd_a, busy_a, done_a, pass_a, err_a, ffv_a, ffvec_a, ffmask_a}, 0);
        check("rst_b", {abcd_b, busy_b, done_b, pass_b, err_b, ffv_b, ffvec_b, ffmask_b}, 0);
        rst_n = 1'b1;
        @(posedge clk); #0.1;

        sweep_a('0, '0, 1'b0);            // ideal bank
        sweep_a(10'h010, '0, 1'b0);       // o5 stuck-at-0
        sweep_a('0, '0, 1'b1);            // start pokes mid-sweep
        sweep_a('0, 10'h3FF, 1'b0);       // every output stuck-at-1
        repeat (5) begin
            r0 = 10'($urandom & $urandom);
            r1 = 10'($urandom & $urandom & $urandom) & ~r0;
            sweep_a(r0, r1, 1'($urandom_range(0, 1)));
        end
        reset_abort();
        loop_b();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
